// File: rtl/renesas_clkgen_pkg.sv
// Package: renesas_clkgen_pkg
// Shared types for the RC38612A clock-generator programming block.
//   cfg_row_t  : one table row {dev_sel, reg_a, dat}
//   ADDR7_DEV* : 7-bit I2C addresses of the two generators
//   state_t    : sequencer states
//   addr_byte(): address byte {addr7, W=0} for a row
package renesas_clkgen_pkg;

  typedef struct packed {
    logic       dev_sel;
    logic [7:0] reg_a;
    logic [7:0] dat;
  } cfg_row_t;

  localparam logic [6:0] ADDR7_DEV0 = 7'h58;
  localparam logic [6:0] ADDR7_DEV1 = 7'h59;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_START,
    ST_ADDR,
    ST_REG,
    ST_DATA,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic [7:0] addr_byte(input logic dev_sel);
    return {(dev_sel ? ADDR7_DEV1 : ADDR7_DEV0), 1'b0};
  endfunction

endpackage

// File: rtl/renesas_clkgen_i2c_cfg_if.sv
// Interface: renesas_clkgen_i2c_cfg_if
// Open-drain I2C bus split into sampled pad levels and pull-low enables.
//   scl_i, sda_i   : pad levels seen by the master
//   scl_oe, sda_oe : 1 = pull the line low, 0 = release to the pull-up
// Modports: master (the configuration engine), slave (pad wrapper side).
interface renesas_clkgen_i2c_cfg_if;
  logic scl_i;
  logic sda_i;
  logic scl_oe;
  logic sda_oe;

  modport master (input scl_i, input sda_i, output scl_oe, output sda_oe);
  modport slave  (output scl_i, output sda_i, input scl_oe, input sda_oe);
endinterface

// File: rtl/renesas_clkgen_cfg_rom.sv
// Module: renesas_clkgen_cfg_rom
// Combinational register table written to the two generators.
//   idx : row index (rows past the table read as all zeros)
//   row : {dev_sel, reg_a, dat}
module renesas_clkgen_cfg_rom
  import renesas_clkgen_pkg::*;
(
  input  logic [7:0] idx,
  output cfg_row_t   row
);

  always_comb begin
    // NOTE: default first so every path assigns row; otherwise a latch is inferred.
    row = '0;
    case (idx)
      8'd0:  row = '{1'b0, 8'h00, 8'hA5};
      8'd1:  row = '{1'b0, 8'h01, 8'h3C};
      8'd2:  row = '{1'b0, 8'h10, 8'h81};
      8'd3:  row = '{1'b1, 8'h00, 8'h5A};
      8'd4:  row = '{1'b1, 8'h01, 8'hC3};
      8'd5:  row = '{1'b0, 8'h20, 8'h7E};
      8'd6:  row = '{1'b1, 8'h20, 8'hE7};
      8'd7:  row = '{1'b0, 8'h31, 8'h01};
      8'd8:  row = '{1'b1, 8'h31, 8'hFF};
      8'd9:  row = '{1'b0, 8'h40, 8'h00};
      8'd10: row = '{1'b1, 8'h40, 8'h96};
      8'd11: row = '{1'b0, 8'h52, 8'h69};
      8'd12: row = '{1'b1, 8'h52, 8'h0F};
      8'd13: row = '{1'b0, 8'h6F, 8'hF0};
      8'd14: row = '{1'b1, 8'h6F, 8'h55};
      8'd15: row = '{1'b0, 8'h7F, 8'hAA};
      default: row = '0;
    endcase
  end

endmodule

// File: rtl/renesas_clkgen_i2c_cfg.sv
// Module: renesas_clkgen_i2c_cfg
// After reset, waits for power-up, then writes every table row as one
// I2C transaction (START, addr, reg, dat, STOP) to the generator at
// 0x58 or 0x59. Stops on the first NACK.
//   clk, rst_n : system clock, async active-low reset (release synchronised)
//   i2c        : open-drain bus (master modport)
//   busy       : sequence in progress
//   done       : sticky, whole table ACKed
//   error      : sticky, a NACK was seen; err_idx holds the row
module renesas_clkgen_i2c_cfg
  import renesas_clkgen_pkg::*;
#(
  parameter string SIMULATION    = "false",
  parameter int    CLK_FREQ_HZ   = 300_000_000,
  parameter int    I2C_FREQ_HZ   = 400_000,
  parameter int    PWRUP_US      = 10_000,
  parameter int    PWRUP_SIM_CYC = 1_000,
  parameter int    NUM_ENTRIES   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  renesas_clkgen_i2c_cfg_if.master       i2c,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [7:0]                     err_idx
);

  localparam int QDIV      = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
  localparam int Q_W       = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int PWRUP_CYC = (SIMULATION == "true") ? PWRUP_SIM_CYC
                                                     : (CLK_FREQ_HZ / 1_000_000) * PWRUP_US;
  localparam int P_W       = $clog2(PWRUP_CYC + 1);
  localparam logic [7:0] LAST_ROW = 8'(NUM_ENTRIES - 1);

  // Reset asserts asynchronously through the chain and releases two clocks later.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i2c.scl_i};
      sda_sync <= {sda_sync[0], i2c.sda_i};
    end
  end
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  cfg_row_t rom_row;
  logic [7:0] row_ptr;

  renesas_clkgen_cfg_rom u_rom (
    .idx (row_ptr),
    .row (rom_row)
  );

  state_t         state, next_st;
  logic [P_W-1:0] pwr_cnt;
  logic [7:0]     reg_q, dat_q, shifter;
  logic [2:0]     bit_cnt, gap_cnt;
  logic           nack;
  logic [Q_W-1:0] q_cnt;
  logic [1:0]     phase;
  logic           scl_oe_q, sda_oe_q;
  logic           q_end, tick;

  // Phase 2 is the SCL-high half just after release: a slave stretching
  // SCL keeps the quarter from ending until the line really reads high.
  assign q_end = (q_cnt == Q_W'(QDIV - 1));
  assign tick  = q_end && !(phase == 2'd2 && !scl_s);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= ST_PWRUP;
      next_st  <= ST_REG;
      pwr_cnt  <= P_W'(PWRUP_CYC);
      row_ptr  <= '0;
      reg_q    <= '0;
      dat_q    <= '0;
      shifter  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      nack     <= 1'b0;
      q_cnt    <= '0;
      phase    <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_idx  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every branch sees pre-edge values.
      if (state == ST_PWRUP || state == ST_LOAD) begin
        q_cnt <= '0;
        phase <= '0;
      end else if (tick) begin
        q_cnt <= '0;
        phase <= phase + 2'd1;
      end else if (!q_end) begin
        q_cnt <= q_cnt + Q_W'(1);
      end

      case (state)
        ST_PWRUP: begin
          busy <= 1'b1;
          if (pwr_cnt == '0) state <= ST_LOAD;
          else               pwr_cnt <= pwr_cnt - P_W'(1);
        end

        ST_LOAD: begin
          reg_q   <= rom_row.reg_a;
          dat_q   <= rom_row.dat;
          shifter <= addr_byte(rom_row.dev_sel);
          bit_cnt <= '0;
          nack    <= 1'b0;
          state   <= ST_START;
        end

        // SDA falls in quarter 2 with SCL high, SCL falls at the end.
        ST_START: if (tick) begin
          if (phase == 2'd1) sda_oe_q <= 1'b1;
          if (phase == 2'd3) begin
            scl_oe_q <= 1'b1;
            state    <= ST_ADDR;
          end
        end

        ST_ADDR, ST_REG, ST_DATA: if (tick) begin
          case (phase)
            2'd0: sda_oe_q <= ~shifter[7];
            2'd1: scl_oe_q <= 1'b0;
            2'd3: begin
              scl_oe_q <= 1'b1;
              shifter  <= {shifter[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state   <= ST_ACK;
                next_st <= (state == ST_ADDR) ? ST_REG :
                           (state == ST_REG)  ? ST_DATA : ST_STOP;
              end
            end
            default: ;
          endcase
        end

        ST_ACK: if (tick) begin
          case (phase)
            2'd0: sda_oe_q <= 1'b0;
            2'd1: scl_oe_q <= 1'b0;
            2'd2: nack     <= sda_s;
            2'd3: begin
              scl_oe_q <= 1'b1;
              if (nack) begin
                state <= ST_STOP;
              end else begin
                state   <= next_st;
                shifter <= (next_st == ST_REG) ? reg_q : dat_q;
              end
            end
          endcase
        end

        // SDA is pulled low under SCL low, then rises while SCL is high.
        ST_STOP: if (tick) begin
          case (phase)
            2'd0: sda_oe_q <= 1'b1;
            2'd1: scl_oe_q <= 1'b0;
            2'd2: sda_oe_q <= 1'b0;
            2'd3: begin
              if (nack) begin
                state   <= ST_ERR;
                error   <= 1'b1;
                err_idx <= row_ptr;
                busy    <= 1'b0;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= '0;
              end
            end
          endcase
        end

        ST_GAP: if (tick) begin
          gap_cnt <= gap_cnt + 3'd1;
          if (gap_cnt == 3'd7) begin
            if (row_ptr == LAST_ROW) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              row_ptr <= row_ptr + 8'd1;
              state   <= ST_LOAD;
            end
          end
        end

        ST_DONE, ST_ERR: ;

        default: state <= ST_ERR;
      endcase
    end
  end

  assign i2c.scl_oe = scl_oe_q;
  assign i2c.sda_oe = sda_oe_q;

endmodule

// File: tb/tb_renesas_clkgen_i2c_cfg.sv
// Bench for renesas_clkgen_i2c_cfg: two I2C slaves (0x58, 0x59) modelled
// on one wired-AND bus with pull-ups, logging every ACKed byte. Runs a
// clean pass, a missing-slave NACK, clock stretching on every ACK, and
// a reset during row 2, checking logs, flags and bus timing.
module tb_renesas_clkgen_i2c_cfg;

  localparam int QDIV = 5;  // 8 MHz / (4 * 400 kHz)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy, done, error;
  logic [7:0] err_idx;

  always #5 clk = ~clk;

  renesas_clkgen_i2c_cfg_if bus ();

  logic slv_scl_hold, slv_sda_low;
  logic scl_line, sda_line;
  assign scl_line  = !(bus.scl_oe || slv_scl_hold);
  assign sda_line  = !(bus.sda_oe || slv_sda_low);
  assign bus.scl_i = scl_line;
  assign bus.sda_i = sda_line;

  renesas_clkgen_i2c_cfg #(
    .SIMULATION    ("true"),
    .CLK_FREQ_HZ   (8_000_000),
    .I2C_FREQ_HZ   (400_000),
    .PWRUP_US      (10),
    .PWRUP_SIM_CYC (50),
    .NUM_ENTRIES   (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i2c     (bus),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .err_idx (err_idx)
  );

  // Expected table {dev_sel, reg, dat}
  logic [16:0] exp_tab [16] = '{
    17'h000A5, 17'h0013C, 17'h01081, 17'h1005A,
    17'h101C3, 17'h0207E, 17'h120E7, 17'h03101,
    17'h131FF, 17'h04000, 17'h14096, 17'h05269,
    17'h1520F, 17'h06FF0, 17'h16F55, 17'h07FAA
  };

  function automatic logic [7:0] exp_byte(input int idx);
    logic [16:0] e;
    e = exp_tab[idx / 3];
    case (idx % 3)
      0:       return e[16] ? 8'hB2 : 8'hB0;
      1:       return e[15:8];
      default: return e[7:0];
    endcase
  endfunction

  // ---------------- slave + protocol monitor ----------------
  logic       dev0_on, dev1_on, slv_clr;
  int         stretch_cyc;
  logic [7:0] log_q [$];
  logic       scl_p, sda_p, in_xfer, addressed, have_rise, ack_low;
  logic [7:0] sh;
  int         cyc = 0;
  int         bits, bits_total, byte_no, stretch_left;
  int         last_stop, last_rise, hi_start;
  int         n_start, n_stop, frame_err, gap_err, period_err, high_err;

  assign slv_scl_hold = (stretch_left != 0);
  assign slv_sda_low  = ack_low;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (slv_clr) begin
      scl_p <= 1'b1; sda_p <= 1'b1; in_xfer <= 1'b0; addressed <= 1'b0;
      have_rise <= 1'b0; ack_low <= 1'b0; sh <= '0;
      bits <= 0; bits_total <= 0; byte_no <= 0; stretch_left <= 0;
      last_stop <= cyc; last_rise <= cyc; hi_start <= cyc;
      n_start <= 0; n_stop <= 0; frame_err <= 0; gap_err <= 0;
      period_err <= 0; high_err <= 0;
      log_q.delete();
    end else begin
      scl_p <= scl_line;
      sda_p <= sda_line;
      if (stretch_left != 0) stretch_left <= stretch_left - 1;

      if (scl_line && scl_p && sda_p && !sda_line) begin
        n_start <= n_start + 1;
        in_xfer <= 1'b1; addressed <= 1'b0; have_rise <= 1'b0;
        bits <= 0; bits_total <= 0; byte_no <= 0;
        if (cyc - last_stop < 2 * QDIV) gap_err <= gap_err + 1;
      end else if (scl_line && scl_p && !sda_p && sda_line) begin
        n_stop    <= n_stop + 1;
        in_xfer   <= 1'b0;
        last_stop <= cyc;
        if (addressed && bits_total != 28) frame_err <= frame_err + 1;
      end

      if (scl_line && !scl_p) begin
        hi_start <= cyc;
        if (in_xfer) begin
          if (bits < 8) sh <= {sh[6:0], sda_line};
          bits       <= (bits == 8) ? 0 : bits + 1;
          bits_total <= bits_total + 1;
          if (have_rise && stretch_cyc == 0 && (cyc - last_rise) != 4 * QDIV)
            period_err <= period_err + 1;
          have_rise <= 1'b1;
          last_rise <= cyc;
        end
      end

      if (!scl_line && scl_p) begin
        if (in_xfer && have_rise) begin
          if (cyc - hi_start < QDIV)
            high_err <= high_err + 1;
          else if (stretch_cyc == 0 && (cyc - hi_start) != 2 * QDIV)
            high_err <= high_err + 1;
        end
        if (in_xfer && bits == 8) begin
          byte_no <= byte_no + 1;
          if ((byte_no == 0 && ((sh == 8'hB0 && dev0_on) || (sh == 8'hB2 && dev1_on))) ||
              (byte_no != 0 && addressed)) begin
            addressed <= 1'b1;
            ack_low   <= 1'b1;
            log_q.push_back(sh);
            if (stretch_cyc > 0) stretch_left <= stretch_cyc;
          end
        end else begin
          ack_low <= 1'b0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_to_end(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!(done || error) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, "_finished"}, 32'(done || error), 1);
  endtask

  task automatic check_log(input string tag, input int n);
    check({tag, "_log_size"}, log_q.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), log_q[i], exp_byte(i));
  endtask

  task automatic restart(input logic d1, input int st);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    dev1_on     = d1;
    stretch_cyc = st;
    slv_clr     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    slv_clr = 1'b0;
    rst_n   = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    dev0_on = 1'b1; dev1_on = 1'b1; stretch_cyc = 0; slv_clr = 1'b1;
    rst_n   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_scl_oe",  bus.scl_oe, 0);
    check("rst_sda_oe",  bus.sda_oe, 0);
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_error",   error, 0);
    check("rst_err_idx", err_idx, 0);
    slv_clr = 1'b0;
    rst_n   = 1'b1;

    // 1 + 4 + 6: full table, exact SCL timing, framing
    repeat (10) @(posedge clk);
    #1;
    check("pwrup_busy",   busy, 1);
    check("pwrup_scl_oe", bus.scl_oe, 0);
    run_to_end("t1", 20000);
    check("t1_done",   done, 1);
    check("t1_error",  error, 0);
    check("t1_busy",   busy, 0);
    check("t1_scl_rel", bus.scl_oe, 0);
    check("t1_sda_rel", bus.sda_oe, 0);
    check_log("t1", 48);
    check("t1_starts",     n_start, 16);
    check("t1_stops",      n_stop, 16);
    check("t1_frame_err",  frame_err, 0);
    check("t1_gap_err",    gap_err, 0);
    check("t1_period_err", period_err, 0);
    check("t1_high_err",   high_err, 0);

    // 2: slave 0x59 absent, row 3 NACKs on its address byte
    restart(1'b0, 0);
    run_to_end("t2", 20000);
    check("t2_error",   error, 1);
    check("t2_done",    done, 0);
    check("t2_busy",    busy, 0);
    check("t2_err_idx", err_idx, 3);
    check("t2_starts",  n_start, 4);
    check("t2_stops",   n_stop, 4);
    check("t2_scl_rel", bus.scl_oe, 0);
    check("t2_sda_rel", bus.sda_oe, 0);
    check_log("t2", 9);

    // 3: stretch SCL on every ACK
    restart(1'b1, 30);
    run_to_end("t3", 30000);
    check("t3_done",      done, 1);
    check("t3_error",     error, 0);
    check("t3_stops",     n_stop, 16);
    check("t3_frame_err", frame_err, 0);
    check("t3_high_err",  high_err, 0);
    check_log("t3", 48);

    // 5: reset during the DATA byte of row 2
    restart(1'b1, 0);
    n = 0;
    while (log_q.size() < 8 && n < 10000) begin @(posedge clk); n++; end
    #1;
    check("t5_reach_row2", log_q.size(), 8);
    n = 0;
    while (!(bus.scl_oe && bus.sda_oe) && n < 200) begin @(posedge clk); #1; n++; end
    check("t5_both_low", 32'(bus.scl_oe && bus.sda_oe), 1);
    rst_n = 1'b0;
    #1;
    check("t5_scl_oe_async", bus.scl_oe, 0);
    check("t5_sda_oe_async", bus.sda_oe, 0);
    check("t5_busy_async",   busy, 0);
    repeat (3) @(posedge clk);
    slv_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    slv_clr = 1'b0;
    rst_n   = 1'b1;
    run_to_end("t5", 20000);
    check("t5_done", done, 1);
    check_log("t5", 48);
    check("t5_starts", n_start, 16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
